// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between instruction fetch (I) and load/store (D).
// Optional ARB_ROUND_ROBIN_EN: ties alternate between ports instead of fixed D-over-I priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              grant_win;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    // last_q remembers the previous grant so a tie goes to the other port
    always_comb begin
        grant_win = d_req;
        if (i_req && d_req) begin
            grant_win = ~last_q;
        end
        last_d = last_q;
        if (state_q == IDLE && (i_req || d_req)) begin
            last_d = grant_win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign grant_win = d_req;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_d = grant_win;
                    if (grant_win) begin
                        addr_d   = d_addr;
                        we_d     = d_we;
                        funct3_d = d_funct3;
                        wdata_d  = d_wdata;
                    end else begin
                        addr_d   = i_addr;
                        we_d     = 1'b0;
                        funct3_d = 3'b010;
                        wdata_d  = '0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                // the read word is valid on the last WAIT cycle (counter at 0)
                if (cnt_q == 2'd0) begin
                    if (owner_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        i_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            wdata_q   <= '0;
            cnt_q     <= 2'd0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            funct3_q  <= funct3_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // acks are masked by rst so a transaction cut short by reset never completes
    assign mem_addr   = addr_q;
    assign mem_funct3 = funct3_q;
    assign mem_wdata  = wdata_q;
    assign mem_we     = (state_q == ISSUE) && we_q;
    assign i_ack      = (state_q == RESP) && !owner_q && !rst;
    assign d_ack      = (state_q == RESP) && owner_q && !rst;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign busy       = (state_q != IDLE);
    assign owner      = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized bursts against a transaction-level model of the arbiter,
// with a simple memory that only presents read data exactly LAT cycles after issue.
module tb_mem_port_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [2:0]  d_funct3;
    logic        i_ack, d_ack, mem_we, busy, owner;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_funct3;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_funct3(mem_funct3),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ref_i_rdata = 32'h0;
    logic [31:0] ref_d_rdata = 32'h0;
    bit          last_win = 1'b0;
    bit          busy_prev = 1'b0;
    int          env_cnt = 0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] env_read(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // memory: commits stores, drives valid read data only on the LAT-th cycle after issue
    always @(negedge clk) begin
        if (busy && !busy_prev) env_cnt = 0;
        else if (busy) env_cnt = env_cnt + 1;
        busy_prev = busy;
        if (mem_we) env_mem[mem_addr] = mem_wdata;
        mem_rdata = (busy && env_cnt == LAT) ? env_read(mem_addr) : (32'hBAD00000 | 32'(env_cnt));
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // one burst: requests raised together, model predicts grant order and every cycle's outputs
    task automatic applyStimulus(input bit want_i, input bit want_d, input logic dwe,
                                 input logic [2:0] df3, input logic [31:0] ia,
                                 input logic [31:0] da, input logic [31:0] dwd);
        int n;
        bit port [2];
        bit isst [2];
        int issc [2];
        int ackc [2];
        int s;
        n = 0;
        if (want_i && want_d) begin
`ifdef ARB_ROUND_ROBIN_EN
            port[0] = ~last_win;
`else
            port[0] = 1'b1;
`endif
            port[1] = ~port[0];
            n = 2;
        end else if (want_d) begin
            port[0] = 1'b1;
            n = 1;
        end else begin
            port[0] = 1'b0;
            n = 1;
        end
        s = 0;
        for (int k = 0; k < n; k++) begin
            isst[k] = port[k] && dwe;
            issc[k] = s + 1;
            ackc[k] = s + 2 + (isst[k] ? 0 : LAT);
            s = ackc[k] + 1;
        end
        @(negedge clk);
        i_req = want_i; i_addr = ia;
        d_req = want_d; d_we = dwe; d_funct3 = df3; d_addr = da; d_wdata = dwd;
        for (int c = 1; c <= s; c++) begin
            logic e_iack, e_dack, e_we, e_busy;
            @(negedge clk);
            e_iack = 1'b0; e_dack = 1'b0; e_we = 1'b0; e_busy = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (c >= issc[k] && c <= ackc[k]) e_busy = 1'b1;
                if (c == issc[k]) begin
                    e_we = isst[k];
                    checkOutput("owner", {31'b0, owner}, {31'b0, port[k]});
                    checkOutput("mem_addr", mem_addr, port[k] ? da : ia);
                    checkOutput("mem_funct3", {29'b0, mem_funct3}, {29'b0, (port[k] ? df3 : 3'b010)});
                    if (isst[k]) checkOutput("mem_wdata", mem_wdata, dwd);
                    if (port[k]) begin
                        d_addr = $urandom; d_wdata = $urandom;
                    end else begin
                        i_addr = $urandom;
                    end
                end
                if (c == ackc[k]) begin
                    if (port[k]) begin
                        e_dack = 1'b1;
                        if (isst[k]) ref_mem[da] = dwd;
                        else ref_d_rdata = ref_read(da);
                        d_req = 1'b0;
                    end else begin
                        e_iack = 1'b1;
                        ref_i_rdata = ref_read(ia);
                        i_req = 1'b0;
                    end
                    last_win = port[k];
                end
            end
            checkOutput("i_ack", {31'b0, i_ack}, {31'b0, e_iack});
            checkOutput("d_ack", {31'b0, d_ack}, {31'b0, e_dack});
            checkOutput("mem_we", {31'b0, mem_we}, {31'b0, e_we});
            checkOutput("busy", {31'b0, busy}, {31'b0, e_busy});
            checkOutput("i_rdata", i_rdata, ref_i_rdata);
            checkOutput("d_rdata", d_rdata, ref_d_rdata);
        end
        checkOutput("owner_last", {31'b0, owner}, {31'b0, last_win});
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b000;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_busy", {31'b0, busy}, 32'h0);
        checkOutput("rst_owner", {31'b0, owner}, 32'h0);
        checkOutput("rst_acks", {30'b0, i_ack, d_ack}, 32'h0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_i_rdata", i_rdata, 32'h0);
        checkOutput("rst_d_rdata", d_rdata, 32'h0);

        env_mem[32'h10] = 32'h00500093; ref_mem[32'h10] = 32'h00500093;
        env_mem[32'h80] = 32'h12345678; ref_mem[32'h80] = 32'h12345678;

        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h10, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'b010, 32'h0, 32'h40, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h80, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h10, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'b000, 32'h80, 32'h44, 32'hCAFEF00D);

        // reset while the fetch is waiting on memory
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h80;
        @(negedge clk);
        checkOutput("rstw_issue_busy", {31'b0, busy}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; i_req = 1'b0;
        ref_i_rdata = 32'h0; ref_d_rdata = 32'h0; last_win = 1'b0;
        checkOutput("rstw_busy", {31'b0, busy}, 32'h0);
        checkOutput("rstw_owner", {31'b0, owner}, 32'h0);
        checkOutput("rstw_i_rdata", i_rdata, 32'h0);
        checkOutput("rstw_d_rdata", d_rdata, 32'h0);
        for (int c = 0; c < 6; c++) begin
            checkOutput("rstw_no_ack", {30'b0, i_ack, d_ack}, 32'h0);
            @(negedge clk);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h10, 32'h0, 32'h0);

        for (int it = 0; it < 40; it++) begin
            int pat;
            pat = $urandom_range(1, 3);
            applyStimulus(pat[0], pat[1], 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          32'($urandom_range(0, 31)) << 2, 32'($urandom_range(0, 31)) << 2,
                          $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
